dmem_arbiter: RTL and testbench

- Shares the single data-memory/IO port (datamem: RAM plus memory-mapped I/O, addr[7]=1 selects I/O) between two requesters:
  - Port A: the CPU MEM stage.
  - Port B: a secondary master (program loader / debug / DMA).
- A normally owns the bus. B accesses are inserted as one-cycle bus steals, and A stalls if it needs the bus during a steal.
- A starvation counter guarantees B progress under continuous CPU traffic.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory/IO port: the CPU MEM stage (A)
// owns the bus by default and port B is slotted in as single-cycle bus steals.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter bit          B_IO_WR_EN   = 1'b0
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_stall,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_datain,
    output logic        m_we,
    input  logic [31:0] m_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        B_ACC  = 2'd1,
        B_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [31:0] b_rdata_reg;
    logic        b_ack_reg;
    logic        b_err_reg;
    logic        blk;
    logic        b_grant;

    // A write from B into the I/O window is suppressed unless explicitly allowed.
    assign blk     = b_addr[7] & ~B_IO_WR_EN & b_we;
    assign b_grant = b_req & (~a_req | (wait_cnt_reg == LIMIT));

    always_comb begin
        m_addr   = a_addr;
        m_datain = a_wdata;
        m_we     = a_req & a_we;
        a_stall  = 1'b0;
        if (state_reg == B_ACC) begin
            m_addr   = b_addr;
            m_datain = b_wdata;
            m_we     = b_we & ~blk;
            a_stall  = a_req;
        end
    end

    assign a_rdata = m_dataout;
    assign b_rdata = b_rdata_reg;
    assign b_ack   = b_ack_reg;
    assign b_err   = b_err_reg;

    always_ff @(posedge clock or posedge clrn) begin
        if (clrn) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            b_rdata_reg  <= 32'd0;
            b_ack_reg    <= 1'b0;
            b_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!b_req) begin
                        wait_cnt_reg <= 4'd0;
                    end else if (b_grant) begin
                        state_reg    <= B_ACC;
                        wait_cnt_reg <= 4'd0;
                    end else begin
                        // B lost a tie to A; count towards the forced steal.
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                B_ACC: begin
                    state_reg <= B_DONE;
                    if (!b_we) begin
                        b_rdata_reg <= m_dataout;
                    end
                    b_ack_reg <= 1'b1;
                    b_err_reg <= blk;
                end
                B_DONE: begin
                    // b_req is deliberately ignored here so A always gets this cycle.
                    state_reg <= IDLE;
                    b_ack_reg <= 1'b0;
                    b_err_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    wait_cnt_reg <= 4'd0;
                    b_ack_reg    <= 1'b0;
                    b_err_reg    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected bus writes, stalls
// and B completions; a negedge monitor pops and compares as the DUT presents them.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        clrn;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_stall;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ack, b_err;
    logic [31:0] m_addr, m_datain, m_dataout;
    logic        m_we;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    wr_t  exp_wr[$];
    ack_t exp_ack[$];
    int   exp_stall[$];

    // Behavioural datamem: 32-word RAM plus four I/O registers at addr[7]=1.
    logic [31:0] mem [32];
    logic [31:0] io  [4];
    logic        pl_we = 1'b0;
    logic        pl_io = 1'b0;
    logic [4:0]  pl_idx = 5'd0;
    logic [31:0] pl_data = 32'd0;

    assign m_dataout = m_addr[7] ? io[m_addr[3:2]] : mem[m_addr[6:2]];

    always @(posedge clock) begin
        if (pl_we) begin
            if (pl_io) io[pl_idx[1:0]] <= pl_data;
            else       mem[pl_idx]     <= pl_data;
        end else if (m_we) begin
            if (m_addr[7]) io[m_addr[3:2]] <= m_datain;
            else           mem[m_addr[6:2]] <= m_datain;
        end
    end

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_arbiter #(.STARVE_LIMIT(3), .B_IO_WR_EN(1'b0)) dut (
        .clock    (clock),
        .clrn     (clrn),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .a_stall  (a_stall),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_rdata  (b_rdata),
        .b_ack    (b_ack),
        .b_err    (b_err),
        .m_addr   (m_addr),
        .m_datain (m_datain),
        .m_we     (m_we),
        .m_dataout(m_dataout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, got, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic io_sel, input int idx, input logic [31:0] data);
        pl_we   = 1'b1;
        pl_io   = io_sel;
        pl_idx  = 5'(idx);
        pl_data = data;
        tick(1);
        pl_we   = 1'b0;
    endtask

    // Monitor: every output event must match the head of its expectation queue.
    always @(negedge clock) begin
        if (a_stall) begin
            if (exp_stall.size() == 0) check("unexpected a_stall", 32'd1, 32'd0);
            else check("a_stall cycle", 32'(cyc), 32'(exp_stall.pop_front()));
        end
        if (m_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected m_we addr", m_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("m_we cycle", 32'(cyc), 32'(w.cyc));
                check("m_we addr", m_addr, w.addr);
                check("m_we data", m_datain, w.data);
            end
        end
        if (b_ack) begin
            if (exp_ack.size() == 0) begin
                check("unexpected b_ack", 32'd1, 32'd0);
            end else begin
                ack_t a;
                a = exp_ack.pop_front();
                check("b_ack cycle", 32'(cyc), 32'(a.cyc));
                check("b_rdata", b_rdata, a.rdata);
                check("b_err", {31'd0, b_err}, {31'd0, a.err});
            end
        end
    end

    initial begin
        int n;
        clrn    = 1'b1;
        a_req   = 1'b1;
        a_we    = 1'b0;
        a_addr  = 32'h20;
        a_wdata = 32'h0;
        b_req   = 1'b1;
        b_we    = 1'b0;
        b_addr  = 32'h14;
        b_wdata = 32'h0;

        // Reset held with both masters requesting; preload memory meanwhile.
        preload(1'b0, 4, 32'hDEAD_BEEF);
        preload(1'b0, 5, 32'hCAFE_F00D);
        preload(1'b0, 6, 32'h6666_6666);
        preload(1'b0, 8, 32'h1234_5678);
        preload(1'b1, 0, 32'h1111_1111);
        check("reset b_ack", {31'd0, b_ack}, 32'd0);
        check("reset b_rdata", b_rdata, 32'd0);
        check("reset a_stall", {31'd0, a_stall}, 32'd0);
        check("reset m_addr", m_addr, 32'h20);
        check("reset a_rdata", a_rdata, 32'h1234_5678);

        // Release: A wins 4 tie cycles, then B is forced on the bus.
        clrn = 1'b0;
        n = cyc;
        exp_stall.push_back(n + 4);
        exp_ack.push_back('{n + 5, 32'hCAFE_F00D, 1'b0});
        tick(5);
        b_req = 1'b0;
        a_req = 1'b0;
        tick(1);

        // Idle B read: bus is free, ack two cycles after sampling.
        n = cyc;
        b_req  = 1'b1;
        b_we   = 1'b0;
        b_addr = 32'h10;
        exp_ack.push_back('{n + 2, 32'hDEAD_BEEF, 1'b0});
        tick(1);
        check("idle read m_addr", m_addr, 32'h10);
        tick(1);
        b_req = 1'b0;
        tick(1);

        // Contention: continuous CPU writes against a B write.
        n = cyc;
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 32'h04;
        b_wdata = 32'h55;
        for (int k = 0; k < 4; k++) begin
            a_req   = 1'b1;
            a_we    = 1'b1;
            a_addr  = 32'h40 + 32'(4 * k);
            a_wdata = 32'h100 + 32'(k);
            exp_wr.push_back('{n + k, 32'h40 + 32'(4 * k), 32'h100 + 32'(k)});
            tick(1);
        end
        a_addr  = 32'h50;
        a_wdata = 32'h104;
        exp_wr.push_back('{n + 4, 32'h04, 32'h55});
        exp_stall.push_back(n + 4);
        exp_wr.push_back('{n + 5, 32'h50, 32'h104});
        exp_ack.push_back('{n + 5, 32'hDEAD_BEEF, 1'b0});
        tick(1);
        b_req = 1'b0;
        tick(1);
        a_req = 1'b0;
        a_we  = 1'b0;
        tick(1);
        check("mem[0x04] after steal", mem[1], 32'h55);
        check("mem[0x50] after stall", mem[20], 32'h104);

        // Steal while A idle: one write, no stall.
        n = cyc;
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 32'h0C;
        b_wdata = 32'h77;
        exp_wr.push_back('{n + 1, 32'h0C, 32'h77});
        exp_ack.push_back('{n + 2, 32'hDEAD_BEEF, 1'b0});
        tick(2);
        b_req = 1'b0;
        tick(1);
        check("mem[0x0C] after idle steal", mem[3], 32'h77);

        // Blocked I/O write: no bus write, ack with error.
        n = cyc;
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 32'h80;
        b_wdata = 32'h99;
        exp_ack.push_back('{n + 2, 32'hDEAD_BEEF, 1'b1});
        tick(1);
        check("blocked m_we", {31'd0, m_we}, 32'd0);
        check("blocked m_addr", m_addr, 32'h80);
        tick(1);
        b_req = 1'b0;
        tick(1);
        check("io[0] unchanged", io[0], 32'h1111_1111);

        // Async reset during B_ACC abandons the write.
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 32'h18;
        b_wdata = 32'h0BAD;
        a_req   = 1'b0;
        a_we    = 1'b0;
        a_addr  = 32'h30;
        tick(1);
        clrn  = 1'b1;
        a_req = 1'b1;
        #1;
        check("mid-reset a_stall", {31'd0, a_stall}, 32'd0);
        check("mid-reset m_addr", m_addr, 32'h30);
        check("mid-reset b_ack", {31'd0, b_ack}, 32'd0);
        b_req = 1'b0;
        tick(2);
        clrn  = 1'b0;
        a_req = 1'b0;
        tick(4);
        check("mem[0x18] unwritten", mem[6], 32'h6666_6666);

        check("pending writes", 32'(exp_wr.size()), 32'd0);
        check("pending acks", 32'(exp_ack.size()), 32'd0);
        check("pending stalls", 32'(exp_stall.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
